// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: pulls one instruction byte per transfer, splits it into
// icode/ifun/rA/rB/valC and hands the result to decode over valid/ready.
module y86_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_load,
   input  logic [63:0] pc_new,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_rvalid,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic        inst_err
);

   typedef enum logic [2:0] {
      ST_OP,
      ST_REG,
      ST_CONST,
      ST_OUT,
      ST_HALTED
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [3:0]  icode_q, icode_d;
   logic [3:0]  ifun_q, ifun_d;
   logic [3:0]  ra_q, ra_d;
   logic [3:0]  rb_q, rb_d;
   logic [63:0] valc_q, valc_d;
   logic [63:0] valp_q, valp_d;
   logic [3:0]  off_q, off_d;
   logic [2:0]  k_q, k_d;
   logic        first_q;

   logic        byte_done;
   logic        handshake;
   logic [3:0]  new_icode;

   function automatic logic [3:0] inst_len(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h6, 4'hA, 4'hB: inst_len = 4'd2;
         4'h7, 4'h8:             inst_len = 4'd9;
         4'h3, 4'h4, 4'h5:       inst_len = 4'd10;
         default:                inst_len = 4'd1;
      endcase
   endfunction

   function automatic logic has_reg(input logic [3:0] ic);
      case (ic)
         4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
         default:                                  has_reg = 1'b0;
      endcase
   endfunction

   function automatic logic has_const(input logic [3:0] ic);
      case (ic)
         4'h3, 4'h4, 4'h5, 4'h7, 4'h8: has_const = 1'b1;
         default:                      has_const = 1'b0;
      endcase
   endfunction

   // Byte offset within the instruction doubles as the fetch address offset.
   assign mem_req    = !first_q && (state_q == ST_OP || state_q == ST_REG || state_q == ST_CONST);
   assign mem_addr   = pc_q + {60'd0, off_q};
   assign inst_valid = (state_q == ST_OUT);
   assign inst_err   = inst_valid && (icode_q > 4'hB);
   assign icode      = icode_q;
   assign ifun       = ifun_q;
   assign rA         = ra_q;
   assign rB         = rb_q;
   assign valC       = valc_q;
   assign valP       = valp_q;

   assign byte_done  = mem_req && mem_rvalid;
   assign handshake  = inst_valid && inst_ready;
   assign new_icode  = mem_rdata[7:4];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      icode_d = icode_q;
      ifun_d  = ifun_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      valc_d  = valc_q;
      valp_d  = valp_q;
      off_d   = off_q;
      k_d     = k_q;

      case (state_q)
         ST_OP: begin
            if (byte_done) begin
               icode_d = new_icode;
               ifun_d  = mem_rdata[3:0];
               ra_d    = 4'hF;
               rb_d    = 4'hF;
               valc_d  = 64'd0;
               k_d     = 3'd0;
               off_d   = 4'd1;
               if (has_reg(new_icode)) begin
                  state_d = ST_REG;
               end else if (has_const(new_icode)) begin
                  state_d = ST_CONST;
               end else begin
                  state_d = ST_OUT;
                  valp_d  = pc_q + {60'd0, inst_len(new_icode)};
               end
            end
         end
         ST_REG: begin
            if (byte_done) begin
               ra_d  = mem_rdata[7:4];
               rb_d  = mem_rdata[3:0];
               off_d = 4'd2;
               if (has_const(icode_q)) begin
                  state_d = ST_CONST;
               end else begin
                  state_d = ST_OUT;
                  valp_d  = pc_q + {60'd0, inst_len(icode_q)};
               end
            end
         end
         ST_CONST: begin
            if (byte_done) begin
               valc_d[{k_q, 3'b000} +: 8] = mem_rdata;
               k_d   = k_q + 3'd1;
               off_d = off_q + 4'd1;
               if (k_q == 3'd7) begin
                  state_d = ST_OUT;
                  valp_d  = pc_q + {60'd0, inst_len(icode_q)};
               end
            end
         end
         ST_OUT: begin
            if (handshake) begin
               pc_d    = valp_q;
               off_d   = 4'd0;
               state_d = (icode_q == 4'h0 || icode_q > 4'hB) ? ST_HALTED : ST_OP;
            end
         end
         default: begin
         end
      endcase

      // A redirect overrides whatever the current state decided this cycle.
      if (pc_load) begin
         state_d = ST_OP;
         pc_d    = pc_new;
         ra_d    = 4'hF;
         rb_d    = 4'hF;
         valc_d  = 64'd0;
         off_d   = 4'd0;
         k_d     = 3'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OP;
         pc_q    <= RESET_PC;
         icode_q <= 4'h0;
         ifun_q  <= 4'h0;
         ra_q    <= 4'hF;
         rb_q    <= 4'hF;
         valc_q  <= 64'd0;
         valp_q  <= 64'd0;
         off_q   <= 4'd0;
         k_q     <= 3'd0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         icode_q <= icode_d;
         ifun_q  <= ifun_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         valc_q  <= valc_d;
         valp_q  <= valp_d;
         off_q   <= off_d;
         k_q     <= k_d;
         first_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed bench for y86_fetch_unit: a table of single instructions plus
// hand-written sequences for streaming, stalls, redirects, halting and reset.
module tb_y86_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_load = 1'b0;
   logic [63:0] pc_new = 64'd0;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_rvalid = 1'b1;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic        inst_err;

   logic [7:0]  mem [0:4095];
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic [63:0] pc;
      int          n;
      logic [79:0] bytes;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [63:0] valc;
      logic [63:0] valp;
      logic        err;
   } vec_t;

   vec_t vecs [16];

   y86_fetch_unit #(.RESET_PC(64'h0)) dut (
      .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_new(pc_new),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .icode(icode), .ifun(ifun),
      .rA(rA), .rB(rB), .valC(valC), .valP(valP), .inst_err(inst_err)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr[11:0]];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bytes are given left-aligned: the first instruction byte is bits [79:72].
   task automatic loadBytes(input logic [63:0] pc, input int n, input logic [79:0] bytes);
      logic [63:0] a;
      for (int i = 0; i < n; i++) begin
         a = pc + 64'(i);
         mem[a[11:0]] = bytes[79 - 8 * i -: 8];
      end
   endtask

   task automatic redirect(input logic [63:0] target);
      @(negedge clk);
      pc_load = 1'b1;
      pc_new  = target;
      @(negedge clk);
      pc_load = 1'b0;
   endtask

   task automatic waitValid(input int limit, output int cycles);
      cycles = 0;
      while (!inst_valid && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic handshake();
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      int c;
      loadBytes(v.pc, v.n, v.bytes);
      redirect(v.pc);
      waitValid(40, c);
      checkOutput($sformatf("v%0d.latency", idx), 64'(c), 64'(v.n));
      checkOutput($sformatf("v%0d.icode", idx), icode, v.icode);
      checkOutput($sformatf("v%0d.ifun", idx), ifun, v.ifun);
      checkOutput($sformatf("v%0d.rA", idx), rA, v.ra);
      checkOutput($sformatf("v%0d.rB", idx), rB, v.rb);
      checkOutput($sformatf("v%0d.valC", idx), valC, v.valc);
      checkOutput($sformatf("v%0d.valP", idx), valP, v.valp);
      checkOutput($sformatf("v%0d.err", idx), inst_err, v.err);
      handshake();
   endtask

   initial begin
      int c, seen, reqInHalt, stallErr, holdErr, idle;
      logic prevStall;
      logic [63:0] prevAddr;
      int          expAt [4] = '{2, 12, 14, 16};
      logic [3:0]  expIc [4] = '{4'h6, 4'h7, 4'h9, 4'h0};
      logic [63:0] expP  [4] = '{64'd2, 64'd11, 64'd12, 64'd13};

      vecs[0]  = '{64'h0, 10, 80'h30F3_0A00_0000_0000_0000, 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'hA, 1'b0};
      vecs[1]  = '{64'h0, 2, 80'h6001_0000_0000_0000_0000, 4'h6, 4'h0, 4'h0, 4'h1, 64'h0, 64'h2, 1'b0};
      vecs[2]  = '{64'h2, 9, 80'h7020_0000_0000_0000_0000, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'hB, 1'b0};
      vecs[3]  = '{64'hB, 1, 80'h9000_0000_0000_0000_0000, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'hC, 1'b0};
      vecs[4]  = '{64'hC, 1, 80'h0000_0000_0000_0000_0000, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hD, 1'b0};
      vecs[5]  = '{64'h100, 10, 80'h5012_0800_0000_0000_0000, 4'h5, 4'h0, 4'h1, 4'h2, 64'h8, 64'h10A, 1'b0};
      vecs[6]  = '{64'h200, 10, 80'h4067_8877_6655_4433_2211, 4'h4, 4'h0, 4'h6, 4'h7,
                   64'h1122_3344_5566_7788, 64'h20A, 1'b0};
      vecs[7]  = '{64'h300, 9, 80'h80EF_CDAB_8967_4523_0100, 4'h8, 4'h0, 4'hF, 4'hF,
                   64'h0123_4567_89AB_CDEF, 64'h309, 1'b0};
      vecs[8]  = '{64'h310, 2, 80'h2445_0000_0000_0000_0000, 4'h2, 4'h4, 4'h4, 4'h5, 64'h0, 64'h312, 1'b0};
      vecs[9]  = '{64'h320, 2, 80'hA03F_0000_0000_0000_0000, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h322, 1'b0};
      vecs[10] = '{64'h330, 2, 80'hB05F_0000_0000_0000_0000, 4'hB, 4'h0, 4'h5, 4'hF, 64'h0, 64'h332, 1'b0};
      vecs[11] = '{64'h20, 1, 80'hF000_0000_0000_0000_0000, 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 1'b1};
      vecs[12] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 80'h1000_0000_0000_0000_0000, 4'h1, 4'h0, 4'hF, 4'hF,
                   64'h0, 64'h0, 1'b0};
      vecs[13] = '{64'hFFFF_FFFF_FFFF_FFFA, 10, 80'h30F4_0102_0304_0506_0708, 4'h3, 4'h0, 4'hF, 4'h4,
                   64'h0807_0605_0403_0201, 64'h4, 1'b0};
      vecs[14] = '{64'h340, 2, 80'h62AB_0000_0000_0000_0000, 4'h6, 4'h2, 4'hA, 4'hB, 64'h0, 64'h342, 1'b0};
      vecs[15] = '{64'h350, 1, 80'hD000_0000_0000_0000_0000, 4'hD, 4'h0, 4'hF, 4'hF, 64'h0, 64'h351, 1'b1};

      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

      // Reset values, then the irmovq from reset with ready held high.
      loadBytes(64'h0, 10, 80'h30F3_0A00_0000_0000_0000);
      inst_ready = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst.memReq", mem_req, 0);
      checkOutput("rst.valid", inst_valid, 0);
      checkOutput("rst.icode", icode, 0);
      checkOutput("rst.ifun", ifun, 0);
      checkOutput("rst.rA", rA, 4'hF);
      checkOutput("rst.rB", rB, 4'hF);
      checkOutput("rst.valC", valC, 0);
      checkOutput("rst.valP", valP, 0);
      checkOutput("rst.err", inst_err, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("c1.firstReq", mem_req, 0);
      @(negedge clk);
      checkOutput("c1.req", mem_req, 1);
      checkOutput("c1.addr", mem_addr, 0);
      waitValid(40, c);
      checkOutput("c1.latency", 64'(c), 10);
      checkOutput("c1.icode", icode, 4'h3);
      checkOutput("c1.rA", rA, 4'hF);
      checkOutput("c1.rB", rB, 4'h3);
      checkOutput("c1.valC", valC, 64'd10);
      checkOutput("c1.valP", valP, 64'd10);
      @(negedge clk);
      checkOutput("c1.oneValid", inst_valid, 0);
      inst_ready = 1'b0;

      for (int i = 0; i < 16; i++) applyStimulus(i, vecs[i]);

      // Back-to-back stream ending in halt; fetcher must then stop requesting.
      loadBytes(64'h0, 2, 80'h6001_0000_0000_0000_0000);
      loadBytes(64'h2, 9, 80'h7020_0000_0000_0000_0000);
      loadBytes(64'hB, 2, 80'h9000_0000_0000_0000_0000);
      redirect(64'h0);
      inst_ready = 1'b1;
      seen = 0;
      reqInHalt = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (inst_valid) begin
            if (seen < 4) begin
               checkOutput($sformatf("c2.at%0d", seen), 64'(cyc), 64'(expAt[seen]));
               checkOutput($sformatf("c2.icode%0d", seen), icode, expIc[seen]);
               checkOutput($sformatf("c2.valP%0d", seen), valP, expP[seen]);
            end
            seen++;
         end
         if (cyc > 17 && mem_req) reqInHalt++;
         @(negedge clk);
      end
      inst_ready = 1'b0;
      checkOutput("c2.count", 64'(seen), 4);
      checkOutput("c2.haltReq", 64'(reqInHalt), 0);

      // mem_rvalid toggling on mrmovq: same fields, address held while stalled.
      loadBytes(64'h100, 10, 80'h5012_0800_0000_0000_0000);
      redirect(64'h100);
      mem_rvalid = 1'b0;
      prevStall = mem_req;
      prevAddr = mem_addr;
      stallErr = 0;
      c = 0;
      while (!inst_valid && c < 60) begin
         @(negedge clk);
         c++;
         if (prevStall && mem_addr !== prevAddr) stallErr++;
         mem_rvalid = ~mem_rvalid;
         prevStall = mem_req && !mem_rvalid;
         prevAddr = mem_addr;
      end
      mem_rvalid = 1'b1;
      checkOutput("c3.latency", 64'(c), 20);
      checkOutput("c3.stallAddr", 64'(stallErr), 0);
      checkOutput("c3.rA", rA, 4'h1);
      checkOutput("c3.rB", rB, 4'h2);
      checkOutput("c3.valC", valC, 64'h8);
      checkOutput("c3.valP", valP, 64'h10A);
      handshake();

      // Decode back-pressure on a nop.
      loadBytes(64'h4, 1, 80'h1000_0000_0000_0000_0000);
      redirect(64'h4);
      waitValid(10, c);
      holdErr = 0;
      for (int k = 0; k < 5; k++) begin
         if (!inst_valid || valP !== 64'd5 || mem_req) holdErr++;
         @(negedge clk);
      end
      checkOutput("c4.hold", 64'(holdErr), 0);
      checkOutput("c4.valP", valP, 64'd5);
      handshake();
      checkOutput("c4.nextReq", mem_req, 1);
      checkOutput("c4.nextAddr", mem_addr, 64'd5);

      // Redirect during constant byte 3 of irmovq.
      loadBytes(64'h60, 10, 80'h30F3_0A0B_0C0D_0E0F_1011);
      loadBytes(64'h40, 2, 80'hA02F_0000_0000_0000_0000);
      redirect(64'h60);
      c = 0;
      while (mem_addr !== 64'h65 && c < 10) begin
         @(negedge clk);
         c++;
      end
      checkOutput("c5.reachByte3", mem_addr, 64'h65);
      pc_load = 1'b1;
      pc_new = 64'h40;
      @(negedge clk);
      pc_load = 1'b0;
      checkOutput("c5.noValid", inst_valid, 0);
      checkOutput("c5.addr", mem_addr, 64'h40);
      checkOutput("c5.rA", rA, 4'hF);
      checkOutput("c5.valC", valC, 0);
      waitValid(10, c);
      checkOutput("c5.latency", 64'(c), 2);
      checkOutput("c5.icode", icode, 4'hA);
      checkOutput("c5.rA2", rA, 4'h2);
      checkOutput("c5.rB", rB, 4'hF);
      checkOutput("c5.valP", valP, 64'h42);
      handshake();

      // Invalid opcode halts the fetcher until a redirect.
      loadBytes(64'h20, 1, 80'hF000_0000_0000_0000_0000);
      loadBytes(64'h30, 1, 80'h1000_0000_0000_0000_0000);
      redirect(64'h20);
      waitValid(10, c);
      checkOutput("c6.err", inst_err, 1);
      checkOutput("c6.icode", icode, 4'hF);
      checkOutput("c6.valP", valP, 64'h21);
      handshake();
      idle = 0;
      for (int k = 0; k < 4; k++) begin
         if (mem_req || inst_valid) idle++;
         @(negedge clk);
      end
      checkOutput("c6.halted", 64'(idle), 0);
      redirect(64'h30);
      waitValid(10, c);
      checkOutput("c6.resumeLatency", 64'(c), 1);
      checkOutput("c6.resumeIcode", icode, 4'h1);
      checkOutput("c6.resumeValP", valP, 64'h31);
      handshake();

      // Asynchronous reset in the middle of a constant.
      redirect(64'h60);
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar.memReq", mem_req, 0);
      checkOutput("ar.valid", inst_valid, 0);
      checkOutput("ar.icode", icode, 0);
      checkOutput("ar.rA", rA, 4'hF);
      checkOutput("ar.rB", rB, 4'hF);
      checkOutput("ar.valC", valC, 0);
      checkOutput("ar.valP", valP, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("ar.firstReq", mem_req, 0);
      @(negedge clk);
      checkOutput("ar.req", mem_req, 1);
      checkOutput("ar.addr", mem_addr, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
